// File: rtl/dmem_responder.sv
// Data-memory responder: synchronous word array behind a valid/ready request channel.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module dmem_responder #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int LOGSIZE = $clog2(SIZE);
  localparam int CW      = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_req_ready;
  logic                   r_busy;
  logic                   r_resp_valid;
  logic [WIDTH-1:0]       r_resp_rdata;
  logic                   r_resp_err;

  logic                   r_we;
  logic [LOGSIZE+1:0]     r_addr;
  logic [2:0]             r_funct3;
  logic [WIDTH-1:0]       r_wdata;

  logic [WIDTH-1:0]       r_mem [SIZE];

  logic                   w_accept;
  logic                   w_access;
  logic [LOGSIZE-1:0]     w_idx;
  logic [1:0]             w_off;
  logic                   w_legal;
  logic                   w_misalign;
  logic                   w_err;
  logic [WIDTH-1:0]       w_word;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [WIDTH-1:0]       w_load;
  logic [3:0]             w_be;
  logic [WIDTH-1:0]       w_wword;
  logic                   w_unused;

  assign w_unused = ^req_addr[31:LOGSIZE+2];

  assign w_accept = req_valid && r_req_ready;
  assign w_access = (r_state == BUSY) && (r_cnt == '0) && !reset;
  assign w_idx    = r_addr[LOGSIZE+1:2];
  assign w_off    = r_addr[1:0];

  assign w_legal  = r_we ? (r_funct3 inside {3'b000, 3'b001, 3'b010})
                         : (r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = ((r_funct3[1:0] == 2'b01) && w_off[0]) ||
                      ((r_funct3[1:0] == 2'b10) && (w_off != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif
  assign w_err = !w_legal || w_misalign;

  assign w_word = r_mem[w_idx];
  assign w_byte = 8'(w_word >> {w_off, 3'b000});
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = '0;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'b0, w_byte};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = '0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b0000;
    w_wword = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wword = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wword = r_wdata;
      end
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_addr   <= req_addr[LOGSIZE+1:0];
      r_funct3 <= req_funct3;
      r_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_valid <= 1'b0;
          if (w_accept) begin
            r_state     <= BUSY;
            r_cnt       <= CW'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state      <= RESP;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= (w_err || r_we) ? '0 : w_load;
            r_resp_err   <= w_err;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          if (w_accept) begin
            r_state     <= BUSY;
            r_cnt       <= CW'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=1 and LATENCY=3 instances against a byte-array model.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic        v1, v3;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;

  logic        rdy1, rv1, err1, busy1;
  logic [31:0] rd1;
  logic        rdy3, rv3, err3, busy3;
  logic [31:0] rd3;

  logic        sel;
  logic        w_ready, w_rvalid, w_err;
  logic [31:0] w_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  mem_m [2][1024];

  always #5 clk = ~clk;

  dmem_responder #(.WIDTH(32), .SIZE(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .busy(busy1)
  );

  dmem_responder #(.WIDTH(32), .SIZE(256), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3), .busy(busy3)
  );

  always_comb begin
    w_ready  = sel ? rdy3 : rdy1;
    w_rvalid = sel ? rv3  : rv1;
    w_rdata  = sel ? rd3  : rd1;
    w_err    = sel ? err3 : err1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: memory as bytes, access located by size-aligned offset inside the word.
  task automatic model(input bit s, input bit we, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned au, n, base;
    logic [31:0] v;
    au = a;
    n  = 1 << f3[1:0];
    er = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_MISALIGN_TRAP_EN
    if (!er && (au % n) != 0) er = 1'b1;
`endif
    rd = '0;
    if (er) return;
    base = ((au / 4) % 256) * 4 + ((au % 4) / n) * n;
    if (we) begin
      for (int i = 0; i < int'(n); i++) mem_m[s][base + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(n); i++) v = v | (32'(mem_m[s][base + i]) << (8*i));
      if (!f3[2] && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endtask

  task automatic do_req(input bit s, input bit we, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned n;
    sel = s;
    @(negedge clk);
    n = 0;
    while (!w_ready && n < 50) begin @(negedge clk); n++; end
    check_val("ready_wait", {31'b0, w_ready}, 32'd1);
    req_we = we; req_addr = a; req_funct3 = f3; req_wdata = wd;
    if (s) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    n = 0;
    while (!w_rvalid && n < 40) begin @(posedge clk); #1; n++; end
    check_val("latency", n, s ? 32'd3 : 32'd1);
    rd = w_rdata;
    er = w_err;
    @(posedge clk); #1;
    check_val("pulse_one_cycle", {31'b0, w_rvalid}, 32'd0);
  endtask

  task automatic xact(input bit s, input bit we, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    logic [31:0] mrd;
    logic        mer;
    do_req(s, we, a, f3, wd, rd, er);
    model(s, we, a, f3, wd, mrd, mer);
    check_val("model_rdata", rd, mrd);
    check_val("model_err", {31'b0, er}, {31'b0, mer});
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int unsigned seen;

    sel = 1'b0; v1 = 1'b0; v3 = 1'b0; rst1 = 1'b1; rst3 = 1'b1;
    req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1; rst1 = 1'b0; rst3 = 1'b0;
    check_val("rst1_rvalid", {31'b0, rv1}, 32'd0);
    check_val("rst1_rdata", rd1, 32'd0);
    check_val("rst1_err", {31'b0, err1}, 32'd0);
    check_val("rst1_busy", {31'b0, busy1}, 32'd0);
    check_val("rst1_ready", {31'b0, rdy1}, 32'd1);
    check_val("rst3_rvalid", {31'b0, rv3}, 32'd0);
    check_val("rst3_busy", {31'b0, busy3}, 32'd0);
    check_val("rst3_ready", {31'b0, rdy3}, 32'd1);

    for (int w = 0; w < 16; w++) begin
      xact(1'b0, 1'b1, 32'(w * 4), 3'b010, $urandom, rd, er);
      xact(1'b1, 1'b1, 32'(w * 4), 3'b010, $urandom, rd, er);
    end

    xact(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, rd, er);
    check_val("t1_sw_rdata", rd, 32'd0);
    xact(1'b0, 1'b0, 32'h10, 3'b010, 32'd0, rd, er);
    check_val("t1_lw", rd, 32'hDEAD_BEEF);
    check_val("t1_lw_err", {31'b0, er}, 32'd0);

    xact(1'b0, 1'b1, 32'h13, 3'b000, 32'h80, rd, er);
    xact(1'b0, 1'b0, 32'h10, 3'b010, 32'd0, rd, er);
    check_val("t2_lw", rd, 32'h80AD_BEEF);
    xact(1'b0, 1'b0, 32'h13, 3'b000, 32'd0, rd, er);
    check_val("t2_lb", rd, 32'hFFFF_FF80);
    xact(1'b0, 1'b0, 32'h13, 3'b100, 32'd0, rd, er);
    check_val("t2_lbu", rd, 32'h0000_0080);
    xact(1'b0, 1'b0, 32'h12, 3'b001, 32'd0, rd, er);
    check_val("t2_lh", rd, 32'hFFFF_80AD);
    xact(1'b0, 1'b0, 32'h12, 3'b101, 32'd0, rd, er);
    check_val("t2_lhu", rd, 32'h0000_80AD);

    xact(1'b0, 1'b0, 32'h11, 3'b010, 32'd0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_val("t3_lw_mis_rdata", rd, 32'd0);
    check_val("t3_lw_mis_err", {31'b0, er}, 32'd1);
`else
    check_val("t3_lw_mis_rdata", rd, 32'h80AD_BEEF);
    check_val("t3_lw_mis_err", {31'b0, er}, 32'd0);
`endif

    xact(1'b0, 1'b0, 32'h10, 3'b011, 32'd0, rd, er);
    check_val("t4_ld011_err", {31'b0, er}, 32'd1);
    check_val("t4_ld011_rdata", rd, 32'd0);
    xact(1'b0, 1'b1, 32'h10, 3'b100, 32'h1111_1111, rd, er);
    check_val("t4_st100_err", {31'b0, er}, 32'd1);
    xact(1'b0, 1'b0, 32'h10, 3'b010, 32'd0, rd, er);
    check_val("t4_unchanged", rd, 32'h80AD_BEEF);

`ifdef DMEM_MISALIGN_TRAP_EN
    xact(1'b0, 1'b1, 32'h12, 3'b010, 32'h5555_5555, rd, er);
    check_val("t3_sw_mis_err", {31'b0, er}, 32'd1);
    xact(1'b0, 1'b0, 32'h10, 3'b010, 32'd0, rd, er);
    check_val("t3_sw_mis_unchanged", rd, 32'h80AD_BEEF);
`endif

    // Back-to-back loads with req_valid held high on the LATENCY=3 instance.
    sel = 1'b1;
    @(negedge clk);
    check_val("t5_start_ready", {31'b0, rdy3}, 32'd1);
    model(1'b1, 1'b0, 32'h10, 3'b010, 32'd0, exp_rd, exp_er);
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = '0;
    v3 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check_val("t5_ready", {31'b0, rdy3}, {31'b0, (k % 4) == 3});
      check_val("t5_rvalid", {31'b0, rv3}, {31'b0, (k % 4) == 3});
      check_val("t5_busy", {31'b0, busy3}, 32'd1);
      if ((k % 4) == 3) check_val("t5_rdata", rd3, exp_rd);
      if (k == 11) v3 = 1'b0;
    end
    @(posedge clk); #1;
    check_val("t5_idle_busy", {31'b0, busy3}, 32'd0);
    check_val("t5_idle_rvalid", {31'b0, rv3}, 32'd0);

    // Store interrupted by reset before its access edge must not commit.
    xact(1'b1, 1'b1, 32'h20, 3'b010, 32'hCAFE_F00D, rd, er);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h1234_5678;
    v3 = 1'b1;
    seen = 0;
    @(posedge clk); #1; v3 = 1'b0; seen += rv3;
    @(posedge clk); #1; seen += rv3; rst3 = 1'b1;
    @(posedge clk); #1; seen += rv3; rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; seen += rv3; end
    check_val("t6_no_resp", seen, 32'd0);
    check_val("t6_busy", {31'b0, busy3}, 32'd0);
    check_val("t6_ready", {31'b0, rdy3}, 32'd1);
    xact(1'b1, 1'b0, 32'h420, 3'b010, 32'd0, rd, er);
    check_val("t6_alias_prior", rd, 32'hCAFE_F00D);

    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 32'h3F_FFFF) , 4'b0000, 6'($urandom_range(0, 63))};
      xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
           3'($urandom_range(0, 7)), $urandom, rd, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
